// File: rtl/contador_mod10_crescente.sv
// Multi-digit BCD up-counter with parallel load, count enable, cascade carry (tc)
// and an all-nines flag (full); optional wrap or saturate at the top value.
module contador_mod10_crescente #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  loadn,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  full
);

  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_d;
  logic [DIGITS-1:0]   nine;
  // carry[i] is high when every digit below i reads 9 (pre-edge values)
  logic [DIGITS:0]     carry;
  logic                sat_hold;

  assign carry[0] = 1'b1;
  assign sat_hold = carry[DIGITS] & ~WRAP;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] ld_val;
      logic [3:0] inc_val;
      logic       step;

      assign cur      = count_q[4*gi +: 4];
      assign nine[gi] = (cur == 4'd9);
      assign carry[gi+1] = carry[gi] & nine[gi];
      // Non-BCD load digits are forced to 0 so the counter never leaves BCD space
      assign ld_val   = (data[4*gi +: 4] > 4'd9) ? 4'd0 : data[4*gi +: 4];
      assign inc_val  = nine[gi] ? 4'd0 : cur + 4'd1;
      assign step     = en & carry[gi] & ~sat_hold;

      assign count_d[4*gi +: 4] = !loadn ? ld_val : (step ? inc_val : cur);
    end
  endgenerate

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = carry[DIGITS];
  assign tc    = en & carry[DIGITS];

endmodule

// File: tb/tb_contador_mod10_crescente.sv
// Directed bench for the BCD up-counter: wrap and saturate variants side by side,
// plus a two-instance single-digit cascade that must track the 2-digit counter.
module tb_contador_mod10_crescente;

  logic       clk;
  logic       clrn;
  logic [7:0] data;
  logic       loadn;
  logic       en;

  logic [7:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, full_w, full_s;
  logic [3:0] cnt_lo, cnt_hi;
  logic       tc_lo, tc_hi, full_lo, full_hi;

  int checks   = 0;
  int failures = 0;

  contador_mod10_crescente #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
    .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en),
    .count(cnt_w), .tc(tc_w), .full(full_w)
  );

  contador_mod10_crescente #(.DIGITS(2), .WRAP(1'b0)) u_sat (
    .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en),
    .count(cnt_s), .tc(tc_s), .full(full_s)
  );

  contador_mod10_crescente #(.DIGITS(1), .WRAP(1'b1)) u_lo (
    .clk(clk), .clrn(clrn), .data(data[3:0]), .loadn(loadn), .en(en),
    .count(cnt_lo), .tc(tc_lo), .full(full_lo)
  );

  contador_mod10_crescente #(.DIGITS(1), .WRAP(1'b1)) u_hi (
    .clk(clk), .clrn(clrn), .data(data[7:4]), .loadn(loadn), .en(tc_lo),
    .count(cnt_hi), .tc(tc_hi), .full(full_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("check %s: %0h ok", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    loadn = 1'b0;
    en    = 1'b0;
    data  = v;
    tick();
    loadn = 1'b1;
  endtask

  logic [7:0] exp_seq [5];

  initial begin
    clrn  = 1'b0;
    data  = 8'h00;
    loadn = 1'b1;
    en    = 1'b0;
    #2;
    check("clr_async_w", {24'd0, cnt_w}, 32'h00);
    check("clr_async_s", {24'd0, cnt_s}, 32'h00);

    // 1: release clear, hold for three edges
    @(negedge clk);
    clrn = 1'b1;
    repeat (3) tick();
    check("idle_count", {24'd0, cnt_w}, 32'h00);
    check("idle_tc", {31'd0, tc_w}, 32'd0);
    check("idle_full", {31'd0, full_w}, 32'd0);

    // 2: load 46 then count five edges
    load(8'h46);
    check("load46", {24'd0, cnt_w}, 32'h46);
    exp_seq = '{8'h47, 8'h48, 8'h49, 8'h50, 8'h51};
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("count_step%0d", i), {24'd0, cnt_w}, {24'd0, exp_seq[i]});
      check($sformatf("cascade_step%0d", i), {24'd0, cnt_hi, cnt_lo}, {24'd0, exp_seq[i]});
    end
    check("tc_mid", {31'd0, tc_w}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    repeat (2) tick();
    check("hold51", {24'd0, cnt_w}, 32'h51);

    // 3: load sanitising
    load(8'h9C);
    check("load9C", {24'd0, cnt_w}, 32'h90);
    load(8'hA7);
    check("loadA7", {24'd0, cnt_w}, 32'h07);

    // 4: reach 99, then wrap vs saturate
    load(8'h98);
    @(negedge clk);
    en = 1'b1;
    tick();
    check("to99", {24'd0, cnt_w}, 32'h99);
    check("full99", {31'd0, full_w}, 32'd1);
    check("tc99", {31'd0, tc_w}, 32'd1);
    check("cascade_tc99", {31'd0, tc_hi}, 32'd1);
    tick();
    check("wrap00", {24'd0, cnt_w}, 32'h00);
    check("wrap_tc", {31'd0, tc_w}, 32'd0);
    check("sat99", {24'd0, cnt_s}, 32'h99);
    check("sat_tc", {31'd0, tc_s}, 32'd1);
    check("sat_full", {31'd0, full_s}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    #1;
    check("sat_tc_en0", {31'd0, tc_s}, 32'd0);
    check("sat_full_en0", {31'd0, full_s}, 32'd1);

    // 5: load beats enable
    load(8'h61);
    @(negedge clk);
    loadn = 1'b0;
    en    = 1'b1;
    data  = 8'h25;
    tick();
    loadn = 1'b1;
    check("load_wins", {24'd0, cnt_w}, 32'h25);

    // 6: clear pulse between edges while counting
    load(8'h36);
    @(negedge clk);
    en = 1'b1;
    tick();
    check("at37", {24'd0, cnt_w}, 32'h37);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    check("midclr_count", {24'd0, cnt_w}, 32'h00);
    check("midclr_tc", {31'd0, tc_w}, 32'd0);
    check("midclr_full", {31'd0, full_s}, 32'd0);
    #1;
    clrn = 1'b1;
    tick();
    check("resume01", {24'd0, cnt_w}, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
